rv_pc_gen: RTL
==============

Name: rv_pc_gen

Overview:
- Fetch-side program-counter generator. It sits directly downstream of the EX-stage branch-condition test and consumes its taken flag together with the EX-stage PC, immediate and rs1.
- Owns the 64-bit PC register and runs a req/ack handshake to instruction memory.
- Computes branch/jump targets, redirects the PC, and raises the pipeline flush.
- Drains an in-flight fetch when a redirect arrives mid-request.

Parameters:
- XLEN, 64, datapath/PC width.
- RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- stall_i  in  1  hazard unit: IF/ID cannot accept; block new requests.
- branch_i  in  1  EX instruction is a conditional branch.
- taken_i  in  1  branch condition result from the EX branch test.
- jump_i  in  1  EX instruction is jal or jalr.
- jalr_i  in  1  qualifies jump_i as jalr.
- ex_pc_i  in  XLEN  PC of the EX instruction.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_i  in  XLEN  forwarded rs1 value (used by jalr).
- if_ack_i  in  1  imem accepts request; data valid same cycle.
- if_req_o  out  1  fetch request.
- if_addr_o  out  XLEN  fetch address, equal to pc_q.
- fetch_valid_o  out  1  returned instruction is to be written into IF/ID.
- fetch_pc_o  out  XLEN  PC of the returned instruction.
- flush_o  out  1  kill IF/ID and ID/EX contents (combinational).
- misalign_o  out  1  registered one-cycle pulse: redirect target misaligned.
- misalign_addr_o  out  XLEN  offending target, held until the next misalign.

Behaviour:
- Reset (rst_n_i=0 at an edge), values on the next cycle:
  - pc_q=RESET_PC, state=BOOT, hold_q=0, pend_q=0.
  - misalign_o=0, misalign_addr_o=0.
  - if_req_o=0, fetch_valid_o=0, flush_o=0.
  - Reset mid-request abandons the fetch; imem shares rst_n_i.
- BOOT: lasts exactly one cycle, then RUN. First if_req_o=1 appears 2 cycles after rst_n_i rises.
- Request rule: if_req_o = (state!=BOOT) & (~stall_i | hold_q).
  - hold_q is set when if_req_o=1 and if_ack_i=0; it is cleared on ack.
  - Once raised, req and address stay stable until ack, regardless of stall_i.
- Target computation:
  - jalr_i=1: target = (rs1_i+imm_i) & ~1.
  - Otherwise: target = ex_pc_i+imm_i.
  - Arithmetic is modulo 2^XLEN; wrap is legal.
- Redirect and misalignment:
  - take = (branch_i & taken_i) | jump_i.
  - target[1]=1 counts as misaligned (no compressed ISA).
  - Misaligned take: misalign_o=1 the next cycle, misalign_addr_o=target. No redirect and no flush; the trap unit owns recovery.
  - Aligned take is a redirect.
  - Redirect has priority over stall_i.
- RUN, no redirect:
  - On if_req_o & if_ack_i: fetch_valid_o=1, fetch_pc_o=pc_q, then pc_q <= pc_q+4.
- RUN, redirect:
  - flush_o=1 in the same cycle and fetch_valid_o=0 (a same-cycle ack is discarded).
  - If no request is outstanding unacked (hold_q=0, or ack this cycle): pc_q <= target and stay in RUN. if_addr_o=target on cycle N+1.
  - Otherwise (hold_q=1, no ack): pend_q <= target, go to DRAIN.
- DRAIN:
  - The request stays asserted at the old address.
  - The returning ack is dropped: fetch_valid_o=0.
  - On ack: pc_q <= pend_q, go to RUN.
  - A further redirect in DRAIN overwrites pend_q (latest wins) and asserts flush_o.
  - stall_i does not affect DRAIN.
- Simultaneous ack + redirect in DRAIN: pc_q <= new target, go to RUN.
- No combinational path from if_ack_i to if_req_o.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN and RESET_PC constants.
  - The PC-gen state encoding (BOOT=2'd0, RUN=2'd1, DRAIN=2'd2).
  - The IALIGN constant (4).
- One natural sub-module, rv_target_calc: combinational target adder, jalr LSB masking, and misalignment check. It is reused later by the trap/return path.
- The state machine and registers stay in rv_pc_gen.

Test Plan:
- Reset, then rst_n_i=1, ack tied high: if_req_o rises on cycle 2. Addresses 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, fetch_valid_o=1 on each.
- EX branch at ex_pc=0x80000010, imm=0x40, taken=1, ack high:
  - flush_o=1 that cycle.
  - Next if_addr_o=0x80000050.
  - The instruction fetched in the redirect cycle has fetch_valid_o=0.
- Redirect while req outstanding (ack held low 3 cycles), target 0x80000100:
  - state DRAIN.
  - Address stays at the old PC until ack, the acked fetch is dropped.
  - The following cycle if_addr_o=0x80000100.
- jalr with rs1=0x80000203, imm=0: target 0x80000202 is misaligned. misalign_o pulses 1 cycle, misalign_addr_o=0x80000202, flush_o=0, PC is unchanged.
- jalr with rs1=0x80000201, imm=0: LSB is masked to target 0x80000200, which is aligned, so the redirect goes through.
- stall_i=1 for 2 cycles with hold_q=0: if_req_o=0 and pc_q holds. With stall_i=1 and hold_q=1, req stays high until ack, then drops.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV core definitions: datapath width, reset vector, instruction
// alignment and the PC-generator state encoding.
package rv_pkg;

  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          IALIGN   = 4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pc_state_e;

endpackage

// File: rtl/rv_target_calc.sv
// Branch/jump target adder with jalr LSB masking and the instruction
// alignment check; purely combinational so the trap/return path can reuse it.
module rv_target_calc
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            jalr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  localparam int ALIGN_BIT = $clog2(IALIGN) - 1;

  logic [XLEN-1:0] sum;

  always_comb begin
    sum = jalr_i ? (rs1_i + imm_i) : (pc_i + imm_i);
    target_o = jalr_i ? {sum[XLEN-1:1], 1'b0} : sum;
    // Bit 0 is always clear here, so only the half-word bit can misalign.
    misaligned_o = target_o[ALIGN_BIT];
  end

endmodule

// File: rtl/rv_pc_gen.sv
// Fetch-side PC generator: owns the PC, runs the imem req/ack handshake,
// applies EX-stage redirects and drains a fetch caught mid-flight.
module rv_pc_gen
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv_pkg::RESET_PC)
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic            taken_i,
  input  logic            jump_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            if_ack_i,
  output logic            if_req_o,
  output logic [XLEN-1:0] if_addr_o,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  pc_state_e       state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pend_q;
  logic            hold_q;

  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            take;
  logic            redirect;
  logic            accepted;

  rv_target_calc #(.XLEN(XLEN)) u_target_calc (
    .jalr_i      (jalr_i),
    .pc_i        (ex_pc_i),
    .imm_i       (imm_i),
    .rs1_i       (rs1_i),
    .target_o    (target),
    .misaligned_o(misaligned)
  );

  // hold_q, not if_ack_i, keeps a raised request alive through a stall.
  always_comb begin
    take          = (branch_i & taken_i) | jump_i;
    redirect      = take & ~misaligned & (state_q != BOOT);
    if_req_o      = (state_q != BOOT) & (~stall_i | hold_q);
    accepted      = if_req_o & if_ack_i;
    if_addr_o     = pc_q;
    fetch_pc_o    = pc_q;
    fetch_valid_o = accepted & (state_q == RUN) & ~redirect;
    flush_o       = redirect;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= BOOT;
      pc_q            <= RESET_PC;
      pend_q          <= '0;
      hold_q          <= 1'b0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      hold_q     <= if_req_o & ~if_ack_i;
      misalign_o <= take & misaligned;
      if (take && misaligned) begin
        misalign_addr_o <= target;
      end

      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (redirect) begin
            if (!hold_q || if_ack_i) begin
              pc_q <= target;
            end else begin
              pend_q  <= target;
              state_q <= DRAIN;
            end
          end else if (accepted) begin
            pc_q <= pc_q + XLEN'(IALIGN);
          end
        end
        DRAIN: begin
          // Latest redirect wins, whether it lands with the ack or before it.
          if (accepted) begin
            pc_q    <= redirect ? target : pend_q;
            state_q <= RUN;
          end else if (redirect) begin
            pend_q <= target;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule
